// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int DATA_WIDTH   = 8;
   localparam int CLKS_PER_BIT = 868;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } tx_state_t;

   // Narrower bytes are zero-extended, which leaves the XOR unchanged.
   function automatic logic calc_even_parity(input logic [31:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..ClksPerBit-1 and ticks on the last count.
// Held at zero while clear is high so each bit starts on a full period.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int ClksPerBit = CLKS_PER_BIT,
   localparam int CntW = $clog2(ClksPerBit)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   output logic [CntW-1:0] count,
   output logic            tick
);

   localparam logic [CntW-1:0] LastCount = CntW'(ClksPerBit - 1);

   assign tick = !clear && (count == LastCount);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear || tick)
         count <= '0;
      else
         count <= count + 1'b1;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmit serialiser fed by a FIFO with a one-cycle registered read.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DataWidth  = DATA_WIDTH,
   parameter int ClksPerBit = CLKS_PER_BIT,
   parameter int StopBits   = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_fifo_empty,
   input  logic [DataWidth-1:0] i_fifo_rd_data,
   output logic                 o_fifo_rd_en,
   output logic                 o_tx,
   output logic                 o_busy,
   output logic                 o_frame_done
);

   localparam int CntW = $clog2(ClksPerBit);
   localparam int IdxW = $clog2(DataWidth + 1);
   localparam logic [IdxW-1:0] LastData = IdxW'(DataWidth - 1);
   localparam logic [IdxW-1:0] LastStop = IdxW'(StopBits - 1);
   localparam logic [CntW-1:0] PreLast  = CntW'(ClksPerBit - 2);

   tx_state_t            state;
   logic [DataWidth-1:0] shift;
   logic [DataWidth-1:0] shift_next;
   logic [IdxW-1:0]      idx;
   logic [CntW-1:0]      count;
   logic                 tick;
   logic                 clear;

   assign clear        = (state == IDLE) || (state == FETCH);
   assign shift_next   = shift >> 1;
   assign o_fifo_rd_en = i_rst_n && (state == IDLE) && !i_fifo_empty;

`ifdef UART_TX_PARITY_EN
   logic [DataWidth-1:0] byte_q;
   logic                 parity_bit;
   assign parity_bit = calc_even_parity(32'(byte_q));
`endif

   uart_baud_gen #(.ClksPerBit(ClksPerBit)) u_baud (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .clear (clear),
      .count (count),
      .tick  (tick)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         shift        <= '0;
         idx          <= '0;
         o_tx         <= 1'b1;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
         byte_q       <= '0;
`endif
      end else begin
         // Registered pulse: raised one cycle early so it lands on the last stop cycle.
         o_frame_done <= (state == STOP) && (idx == LastStop) && (count == PreLast);
         case (state)
            IDLE: begin
               if (!i_fifo_empty) begin
                  state  <= FETCH;
                  o_busy <= 1'b1;
               end
            end
            FETCH: begin
               shift <= i_fifo_rd_data;
`ifdef UART_TX_PARITY_EN
               byte_q <= i_fifo_rd_data;
`endif
               state <= START;
               o_tx  <= 1'b0;
            end
            START: begin
               if (tick) begin
                  state <= DATA;
                  o_tx  <= shift[0];
               end
            end
            DATA: begin
               if (tick) begin
                  shift <= shift_next;
                  if (idx == LastData) begin
                     idx   <= '0;
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
                     o_tx  <= parity_bit;
`else
                     state <= STOP;
                     o_tx  <= 1'b1;
`endif
                  end else begin
                     idx  <= idx + 1'b1;
                     o_tx <= shift_next[0];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  state <= STOP;
                  o_tx  <= 1'b1;
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  if (idx == LastStop) begin
                     state  <= IDLE;
                     o_busy <= 1'b0;
                     idx    <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
               o_tx   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (one and two stop bits), each fed by a model FIFO.
// Expected line waveforms are built per byte from the frame format and compared cycle by cycle.
module tb_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] fmem0 [256];
   logic [7:0] fmem1 [256];
   logic [7:0] wp0 = 8'd0, rp0 = 8'd0, wp1 = 8'd0, rp1 = 8'd0;
   logic [7:0] rdata0 = 8'd0, rdata1 = 8'd0;
   logic fe0, fe1;
   logic rd0, tx0, busy0, done0;
   logic rd1, tx1, busy1, done1;
   int   viol = 0;
   int   checks = 0;
   int   failures = 0;
   logic sel = 1'b0;
   logic tx_s, busy_s, rd_s, done_s;

   assign fe0 = (wp0 == rp0);
   assign fe1 = (wp1 == rp1);
   assign tx_s   = sel ? tx1   : tx0;
   assign busy_s = sel ? busy1 : busy0;
   assign rd_s   = sel ? rd1   : rd0;
   assign done_s = sel ? done1 : done0;

   uart_tx #(.DataWidth(8), .ClksPerBit(CPB), .StopBits(1)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_fifo_empty(fe0), .i_fifo_rd_data(rdata0),
      .o_fifo_rd_en(rd0), .o_tx(tx0), .o_busy(busy0), .o_frame_done(done0));

   uart_tx #(.DataWidth(8), .ClksPerBit(CPB), .StopBits(2)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_fifo_empty(fe1), .i_fifo_rd_data(rdata1),
      .o_fifo_rd_en(rd1), .o_tx(tx1), .o_busy(busy1), .o_frame_done(done1));

   // Model FIFO: registered read, data valid the cycle after the pop strobe.
   always @(posedge clk) begin
      if (rst_n && rd0 && (wp0 != rp0)) begin
         rdata0 <= fmem0[rp0];
         rp0    <= rp0 + 8'd1;
      end
      if (rst_n && rd1 && (wp1 != rp1)) begin
         rdata1 <= fmem1[rp1];
         rp1    <= rp1 + 8'd1;
      end
   end

   always @(negedge clk) begin
      #2;
      if (rd0 && (fe0 || busy0)) viol <= viol + 1;
      if (rd1 && (fe1 || busy1)) viol <= viol + 1;
   end

   task automatic push(input int s, input logic [7:0] b);
      if (s == 0) begin
         fmem0[wp0] = b;
         wp0 = wp0 + 8'd1;
      end else begin
         fmem1[wp1] = b;
         wp1 = wp1 + 8'd1;
      end
   endtask

   // Called on a falling edge with the DUT idle; compares every cycle against the model.
   task automatic check_stream(input int s, input bq_t pq, input bq_t eq, input string name);
      logic e_tx[$], e_busy[$], e_rd[$], e_done[$];
      logic bits[$];
      logic [7:0] b;
      bit   bad [4];
      int   sb;
      sb = (s == 0) ? 1 : 2;
      foreach (eq[k]) begin
         b = eq[k];
         e_tx.push_back(1'b1); e_busy.push_back(1'b0); e_rd.push_back(1'b1); e_done.push_back(1'b0);
         e_tx.push_back(1'b1); e_busy.push_back(1'b1); e_rd.push_back(1'b0); e_done.push_back(1'b0);
         bits.delete();
         bits.push_back(1'b0);
         for (int i = 0; i < 8; i++) bits.push_back(b[i]);
         if (P == 1) bits.push_back(^b);
         for (int i = 0; i < sb; i++) bits.push_back(1'b1);
         foreach (bits[j]) begin
            for (int c = 0; c < CPB; c++) begin
               e_tx.push_back(bits[j]);
               e_busy.push_back(1'b1);
               e_rd.push_back(1'b0);
               e_done.push_back((j == bits.size() - 1) && (c == CPB - 1));
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         e_tx.push_back(1'b1); e_busy.push_back(1'b0); e_rd.push_back(1'b0); e_done.push_back(1'b0);
      end
      sel = (s != 0);
      foreach (pq[k]) push(s, pq[k]);
      for (int i = 0; i < e_tx.size(); i++) begin
         #1;
         if (tx_s !== e_tx[i] && !bad[0]) begin
            $display("FAIL %s.tx sample %0d got %b expected %b", name, i, tx_s, e_tx[i]);
            bad[0] = 1; failures++;
         end
         if (busy_s !== e_busy[i] && !bad[1]) begin
            $display("FAIL %s.busy sample %0d got %b expected %b", name, i, busy_s, e_busy[i]);
            bad[1] = 1; failures++;
         end
         if (rd_s !== e_rd[i] && !bad[2]) begin
            $display("FAIL %s.rd_en sample %0d got %b expected %b", name, i, rd_s, e_rd[i]);
            bad[2] = 1; failures++;
         end
         if (done_s !== e_done[i] && !bad[3]) begin
            $display("FAIL %s.frame_done sample %0d got %b expected %b", name, i, done_s, e_done[i]);
            bad[3] = 1; failures++;
         end
         @(negedge clk);
      end
      checks += 5;
      if ((s == 0 ? fe0 : fe1) !== 1'b1) begin
         $display("FAIL %s.fifo_empty got 0 expected 1", name);
         failures++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks += 4;
      if (tx0 !== 1'b1)   begin $display("FAIL reset.tx got %b expected 1", tx0); failures++; end
      if (busy0 !== 1'b0) begin $display("FAIL reset.busy got %b expected 0", busy0); failures++; end
      if (rd0 !== 1'b0)   begin $display("FAIL reset.rd_en got %b expected 0", rd0); failures++; end
      if (done0 !== 1'b0) begin $display("FAIL reset.frame_done got %b expected 0", done0); failures++; end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_idle;
      int bad_tx = 0, bad_busy = 0, bad_rd = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (tx0 !== 1'b1) bad_tx++;
         if (busy0 !== 1'b0) bad_busy++;
         if (rd0 !== 1'b0) bad_rd++;
         @(negedge clk);
      end
      checks += 3;
      if (bad_tx != 0)   begin $display("FAIL idle.tx low cycles got %0d expected 0", bad_tx); failures++; end
      if (bad_busy != 0) begin $display("FAIL idle.busy cycles got %0d expected 0", bad_busy); failures++; end
      if (bad_rd != 0)   begin $display("FAIL idle.rd_en cycles got %0d expected 0", bad_rd); failures++; end
   endtask

   task automatic test_single;
      bq_t q;
      q.push_back(8'hA5);
      check_stream(0, q, q, "single_a5");
      q.delete();
      q.push_back(8'h01);
      check_stream(0, q, q, "single_01");
   endtask

   task automatic test_back_to_back;
      bq_t q;
      q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h3C);
      check_stream(0, q, q, "b2b");
   endtask

   task automatic test_random;
      bq_t q;
      int n;
      for (int r = 0; r < 3; r++) begin
         q.delete();
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         repeat ($urandom_range(0, 6)) @(negedge clk);
         check_stream(0, q, q, "random");
      end
   endtask

   task automatic test_reset_mid;
      bq_t none, q;
      push(0, 8'h55);
      push(0, 8'hC3);
      repeat (19) @(negedge clk);
      #1;
      checks++;
      if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
         $display("FAIL rst_mid.bit3 got tx=%b busy=%b expected tx=0 busy=1", tx0, busy0);
         failures++;
      end
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (tx0 !== 1'b1)   begin $display("FAIL rst_mid.tx got %b expected 1", tx0); failures++; end
      if (busy0 !== 1'b0) begin $display("FAIL rst_mid.busy got %b expected 0", busy0); failures++; end
      if (rd0 !== 1'b0)   begin $display("FAIL rst_mid.rd_en got %b expected 0", rd0); failures++; end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      q.push_back(8'hC3);
      check_stream(0, none, q, "after_rst");
   endtask

   task automatic test_two_stop;
      bq_t q;
      q.push_back(8'h80);
      check_stream(1, q, q, "stop2_80");
      q.delete();
      q.push_back(8'($urandom)); q.push_back(8'($urandom));
      check_stream(1, q, q, "stop2_rand");
   endtask

   task automatic test_protocol;
      checks++;
      if (viol != 0) begin
         $display("FAIL protocol.rd_en_violations got %0d expected 0", viol);
         failures++;
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_two_stop();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
